// File: rtl/nf_reg_file_ctrl.sv
// nf_reg_file_ctrl: zero-sweeps the 32x32 register file after reset, then arbitrates its
// single write port between core writeback (priority) and a debug write channel.
module nf_reg_file_ctrl #(
    parameter int STARVE_LIM = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_wa,
    input  logic [31:0] wb_wd,
    input  logic        dbg_req,
    input  logic [4:0]  dbg_wa,
    input  logic [31:0] dbg_wd,
    output logic        dbg_ack,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        pipe_stall,
    output logic        init_done
);
    typedef enum logic {INIT, RUN} state_t;

    state_t      state, state_next;
    logic [4:0]  sweep, sweep_next;
    logic [3:0]  starve, starve_next;
    logic        run, wb_hit, dbg_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= INIT;
            sweep  <= '0;
            starve <= '0;
        end else begin
            state  <= state_next;
            sweep  <= sweep_next;
            starve <= starve_next;
        end
    end

    // Outputs are gated by rst so the register file is never written while reset is held.
    always_comb begin
        run         = !rst && state == RUN;
        wb_hit      = run && wb_we && wb_wa != '0;
        dbg_ack     = run && !wb_hit && dbg_req;
        dbg_wr      = dbg_ack && dbg_wa != '0;
        rf_we       = !rst && (state == INIT || wb_hit || dbg_wr);
        rf_wa       = rst ? '0 : state == INIT ? sweep : wb_hit ? wb_wa : dbg_wr ? dbg_wa : '0;
        rf_wd       = rst || state == INIT ? '0 : wb_hit ? wb_wd : dbg_wr ? dbg_wd : '0;
        pipe_stall  = rst || state == INIT || 32'(starve) >= STARVE_LIM;
        init_done   = run;
        state_next  = state == INIT && sweep == 5'd31 ? RUN : state;
        sweep_next  = state == INIT ? sweep + 5'd1 : sweep;
        starve_next = run && dbg_req && !dbg_ack ? (starve == 4'd15 ? starve : starve + 4'd1) : '0;
    end
endmodule

// File: tb/tb_nf_reg_file_ctrl.sv
// tb_nf_reg_file_ctrl: directed stimulus queues expected register-file writes; a negedge
// monitor pops and compares one entry per DUT write.
module tb_nf_reg_file_ctrl;
    logic        clk = 0;
    logic        rst = 1;
    logic        wb_we = 0, dbg_req = 0;
    logic [4:0]  wb_wa = 0, dbg_wa = 0;
    logic [31:0] wb_wd = 0, dbg_wd = 0;
    logic        dbg_ack, rf_we, pipe_stall, init_done;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];

    nf_reg_file_ctrl #(.STARVE_LIM(8)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .dbg_req(dbg_req), .dbg_wa(dbg_wa), .dbg_wd(dbg_wd),
        .dbg_ack(dbg_ack),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .pipe_stall(pipe_stall), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every DUT write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got wa=%0d wd=%0h expected no write at %0t", rf_wa, rf_wd, $time);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({rf_wa, rf_wd} !== e) begin
                    errors++;
                    $display("FAIL write: got wa=%0d wd=%0h expected wa=%0d wd=%0h at %0t",
                             rf_wa, rf_wd, e[36:32], e[31:0], $time);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] wa, input logic [31:0] wd);
        exp_q.push_back({wa, wd});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        step();
        @(negedge clk);
        chk("rst_rf_we", 32'(rf_we), 0);
        chk("rst_stall", 32'(pipe_stall), 1);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_dbg_ack", 32'(dbg_ack), 0);
        step();
        rst = 0;
        for (int i = 0; i < 32; i++) begin
            expect_wr(5'(i), 0);
            @(negedge clk);
            chk("sweep_stall", 32'(pipe_stall), 1);
            chk("sweep_init_done", 32'(init_done), 0);
            step();
        end
        @(negedge clk);
        chk("run_init_done", 32'(init_done), 1);
        chk("run_stall", 32'(pipe_stall), 0);
        chk("sweep_drained", exp_q.size(), 0);
        step();

        // Writeback beats a simultaneous debug request
        wb_we = 1; wb_wa = 5; wb_wd = 32'hDEADBEEF;
        dbg_req = 1; dbg_wa = 7; dbg_wd = 32'h12345678;
        expect_wr(5, 32'hDEADBEEF);
        @(negedge clk);
        chk("wb_wins_ack", 32'(dbg_ack), 0);
        step();
        wb_we = 0;
        expect_wr(7, 32'h12345678);
        @(negedge clk);
        chk("dbg_after_wb_ack", 32'(dbg_ack), 1);
        step();

        // Writeback to x0 is not a hit; debug to x0 is acked without a write
        wb_we = 1; wb_wa = 0; wb_wd = 32'hFFFF_FFFF;
        dbg_wa = 3; dbg_wd = 32'h55;
        expect_wr(3, 32'h55);
        @(negedge clk);
        chk("wb_x0_dbg_ack", 32'(dbg_ack), 1);
        step();
        wb_we = 0; dbg_wa = 0; dbg_wd = 32'hBAD;
        @(negedge clk);
        chk("dbg_x0_ack", 32'(dbg_ack), 1);
        chk("dbg_x0_no_we", 32'(rf_we), 0);
        step();
        dbg_req = 0;
        @(negedge clk);
        chk("idle_we", 32'(rf_we), 0);
        chk("idle_ack", 32'(dbg_ack), 0);
        step();

        // Starvation: stall rises after the 8th blocked cycle
        dbg_req = 1; dbg_wa = 9; dbg_wd = 32'hA5;
        wb_we = 1; wb_wa = 1;
        for (int i = 1; i <= 9; i++) begin
            wb_wd = 32'(i);
            expect_wr(1, 32'(i));
            @(negedge clk);
            chk("starve_ack", 32'(dbg_ack), 0);
            chk("starve_stall", 32'(pipe_stall), (i == 9) ? 1 : 0);
            step();
        end
        wb_we = 0;
        expect_wr(9, 32'hA5);
        @(negedge clk);
        chk("starve_release_ack", 32'(dbg_ack), 1);
        chk("starve_release_stall", 32'(pipe_stall), 1);
        step();
        dbg_req = 0;
        @(negedge clk);
        chk("starve_clear_stall", 32'(pipe_stall), 0);
        step();

        // Reset mid-sweep with a pending debug request
        rst = 1; dbg_req = 1; dbg_wa = 4; dbg_wd = 32'h44;
        step();
        rst = 0;
        for (int i = 0; i < 17; i++) begin
            expect_wr(5'(i), 0);
            @(negedge clk);
            chk("sweep1_ack", 32'(dbg_ack), 0);
            step();
        end
        rst = 1;
        @(negedge clk);
        chk("midrst_we", 32'(rf_we), 0);
        chk("midrst_ack", 32'(dbg_ack), 0);
        step();
        rst = 0;
        for (int i = 0; i < 32; i++) begin
            expect_wr(5'(i), 0);
            @(negedge clk);
            chk("sweep2_ack", 32'(dbg_ack), 0);
            step();
        end
        expect_wr(4, 32'h44);
        @(negedge clk);
        chk("post_rst_ack", 32'(dbg_ack), 1);
        chk("post_rst_init_done", 32'(init_done), 1);
        step();
        dbg_req = 0;
        @(negedge clk);
        chk("final_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nf_reg_file_ctrl.md
# nf_reg_file_ctrl

Write-port controller for the 32x32 register file. After reset it sweeps all 32 entries to zero, then arbitrates the single write port between core writeback and a debug write channel. It enforces x0 as read-only zero and stalls the pipeline during the initial sweep and when debug writes are starved. It sits between the pipeline writeback stage, the debug unit and the register file write port (wa3/wd3/we3).

## Interface
Parameters:
- STARVE_LIM, 8: consecutive blocked debug-request cycles before pipe_stall is forced; legal 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- wb_we  in  1  core writeback write enable
- wb_wa  in  5  core writeback address
- wb_wd  in  32  core writeback data
- dbg_req  in  1  debug write request; held high until dbg_ack
- dbg_wa  in  5  debug write address; stable while dbg_req high
- dbg_wd  in  32  debug write data; stable while dbg_req high
- dbg_ack  out  1  debug write granted this cycle
- rf_we  out  1  to register file we3
- rf_wa  out  5  to register file wa3
- rf_wd  out  32  to register file wd3
- pipe_stall  out  1  core must hold pipeline; core drives wb_we=0 from the cycle after it sees pipe_stall high
- init_done  out  1  high once the zero sweep is complete

## Operation
- Two states: INIT, RUN. A 5-bit sweep counter and a 4-bit saturating starve counter.
- rst=1: next state INIT, sweep counter 0, starve counter 0. While rst is high, rf_we=0, dbg_ack=0, pipe_stall=1, init_done=0. rf_wa and rf_wd are 0.
- INIT:
  - rf_we=1, rf_wa=sweep counter, rf_wd=0. The counter increments every cycle.
  - At counter==31, move to RUN on the next edge.
  - pipe_stall=1, init_done=0, dbg_ack=0.
  - wb_we is ignored (dropped). dbg_req stays pending. The starve counter stays at 0.
- RUN: init_done=1. Writeback "hits" when wb_we=1 and wb_wa!=0.
  - Writeback hit: rf_we=1, rf_wa=wb_wa, rf_wd=wb_wd, dbg_ack=0.
  - Otherwise, if dbg_req=1: dbg_ack=1. If dbg_wa!=0, rf_we=1 with rf_wa=dbg_wa and rf_wd=dbg_wd. A debug write to x0 is acked but not written (rf_we=0).
  - Otherwise: rf_we=0, rf_wa=0, rf_wd=0.
  - wb_we=1 with wb_wa=0 never writes. It does not count as a hit, so debug may take that slot.
- Starve counter (RUN only):
  - Increments, saturating at 15, each cycle with dbg_req=1 and dbg_ack=0.
  - Clears on dbg_ack=1, or whenever dbg_req=0.
- pipe_stall = (state==INIT) or (starve counter >= STARVE_LIM).
- rf_we/rf_wa/rf_wd and dbg_ack are combinational from state and current inputs. pipe_stall and init_done depend only on state and counters.

## Timing
- rst deasserted before edge E0: cycles 0..31 write x0..x31 with 0. Cycle 32 is the first RUN cycle, with init_done=1 and pipe_stall=0 (starve counter is 0).
- The write takes effect at the edge that ends the cycle in which rf_we=1. There is zero added latency from wb_we to rf_we.
- Debug handshake: the transfer occurs on an edge where dbg_req=1 and dbg_ack=1. The debug unit may drop dbg_req or present the next request in the following cycle. dbg_ack is never high while dbg_req=0.
- Starvation: with dbg_req high and writeback hitting every cycle, pipe_stall rises in the cycle after the STARVE_LIM-th blocked cycle. The core drops wb_we one cycle later, and dbg_ack follows in that same cycle. pipe_stall falls in the cycle after the ack.
- Simultaneous writeback hit and dbg_req: writeback always wins.
- Reset mid-sweep or mid-RUN: the sweep restarts from x0 and the starve counter clears. A pending dbg_req is not acked until RUN.

## Test plan
- Reset release: hold rst 2 cycles, then release -> rf_we=1 with rf_wa 0..31 and rf_wd=0 over 32 cycles. init_done and pipe_stall toggle at cycle 32, and regfile model is all zero.
- RUN, wb_we=1, wb_wa=5, wb_wd=0xDEADBEEF with dbg_req=1, dbg_wa=7 in the same cycle -> x5 written and dbg_ack=0. Next cycle wb_we=0 -> dbg_ack=1 and x7 written.
- wb_we=1, wb_wa=0 with dbg_req=1, dbg_wa=3, dbg_wd=0x55 -> rf_we=1, rf_wa=3, dbg_ack=1, and x0 is never written. Debug write to x0 -> dbg_ack=1, rf_we=0.
- Starvation with STARVE_LIM=8: continuous wb hits on x1 with dbg_req high -> pipe_stall high in the cycle after the 8th blocked cycle. The bench drops wb_we one cycle later, dbg_ack=1 in that cycle, and pipe_stall low the cycle after.
- rst pulsed at sweep counter=17 with dbg_req held high -> sweep restarts at x0 with no dbg_ack during INIT. dbg_ack=1 in cycle 32 after rst release.
